modulo_updown_counter: RTL
==========================

// Module: modulo_updown_counter
// PURPOSE
//  Parametrised modulo-N up/down counter with synchronous load, set mode
//  (edge-detected manual inc/dec) and registered carry/borrow pulses.
//  Counter primitive for timer/clock datapaths. Units cascade by feeding
//  carry_out/borrow_out into the next stage's count_en with matching dir.
// PARAMETERS
//  WIDTH    7    count register width; requires 2**WIDTH >= MODULUS
//  MODULUS  100  count range 0..MODULUS-1; MODULUS >= 2
//  WRAP     1    1 = wrap at limits; 0 = saturate at limits
// PORTS
//  clk          in   1      single clock, all state on posedge
//  reset        in   1      asynchronous, active-high
//  clear        in   1      synchronous clear to 0
//  load_en      in   1      synchronous load of load_value
//  load_value   in   WIDTH  load data
//  set_mode     in   1      1 = manual adjust, auto count suppressed
//  manual_inc   in   1      level input, acted on at rising edge only
//  manual_dec   in   1      level input, acted on at rising edge only
//  count_en     in   1      auto-count enable (run mode)
//  dir          in   1      1 = up, 0 = down (run mode)
//  count_out    out  WIDTH  current count (registered)
//  carry_out    out  1      1-cycle pulse: up-wrap MODULUS-1 -> 0
//  borrow_out   out  1      1-cycle pulse: down-wrap 0 -> MODULUS-1
//  at_max       out  1      comb: count_out == MODULUS-1
//  at_zero      out  1      comb: count_out == 0
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - reset: count=0, carry_out=0, borrow_out=0, edge-detect history=0.
//  - Priority per cycle: clear > load_en > set_mode adjust > count_en.
//  - clear: count=0; no pulses.
//  - load_en: count=load_value; load_value >= MODULUS clamps to MODULUS-1.
//    No pulses.
//  - set_mode=1: inc_edge = manual_inc & ~inc_q (dec likewise).
//    inc_edge only: +1. dec_edge only: -1. Both or neither: hold.
//    Limits follow WRAP. count_en is ignored. carry_out/borrow_out stay 0
//    (manual adjust never ripples).
//  - Edge history (inc_q/dec_q) updates every cycle in every mode. A level
//    already high when set_mode rises produces no edge.
//  - run (set_mode=0, count_en=1): dir=1 -> +1, dir=0 -> -1.
//    WRAP=1: MODULUS-1 +1 -> 0 with carry_out=1 in the same cycle
//    count_out becomes 0. 0 -1 -> MODULUS-1 with borrow_out=1.
//    WRAP=0: hold at limit; no pulse.
//  - carry_out/borrow_out are registered, high exactly one cycle per wrap,
//    cleared in every other cycle. Never both high.
//  - count_en=0 in run mode: hold; pulses 0.
//  - Latency: every input takes effect at the next posedge.
//    at_max/at_zero track count_out combinationally.
//  - Arithmetic is WIDTH bits. Limit compare happens before the add, so
//    count_out never leaves 0..MODULUS-1.
//  - reset mid-wrap: async reset wins and forces pulses low immediately.
// STRUCTURE
//  - Shared package/header counter_defs: DIR_UP=1'b1, DIR_DOWN=1'b0.
//  - Sub-module rise_edge_detect (1-bit registered history, async reset),
//    instantiated twice: manual_inc, manual_dec.
//  - Top: one next-state always block plus one registered always block.
// TESTING (MODULUS=100, WIDTH=7 unless noted)
//  1 Async reset mid-cycle with count=57 -> count_out=0, pulses 0 before
//    the next edge.
//  2 Run up from 98, 3 cycles -> 99, 0 (carry_out=1 this cycle only), 1;
//    borrow_out always 0.
//  3 Run down from 1, 3 cycles -> 0, 99 (borrow_out=1 once), 98;
//    at_zero high at 0.
//  4 set_mode=1, manual_inc held high 5 cycles -> +1 once; inc and dec
//    rising together -> hold; inc at 99 -> 0 with carry_out=0.
//  5 load_en with 120 -> 99; same cycle as clear=1 -> 0; load with
//    count_en=1 -> loaded value, no increment.
//  6 WRAP=0: up at 99 -> stays 99; down at 0 -> stays 0; no pulses ever.

Source files
------------

// File: rtl/counter_defs.sv
// Shared definitions for the modulo up/down counter family.
package counter_defs;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_CLEAR,
        ACT_LOAD,
        ACT_MANUAL,
        ACT_RUN
    } count_action_e;

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector with a one-bit registered history.
module rise_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sig_q <= 1'b0;
        else       sig_q <= sig;
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/modulo_updown_counter.sv
// Modulo-N up/down counter with clear, clamped load, edge-driven manual
// adjust, and registered carry/borrow pulses for cascading.
module modulo_updown_counter
    import counter_defs::*;
#(
    parameter int WIDTH   = 7,
    parameter int MODULUS = 100,
    parameter int WRAP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_value,
    input  logic             set_mode,
    input  logic             manual_inc,
    input  logic             manual_dec,
    input  logic             count_en,
    input  logic             dir,
    output logic [WIDTH-1:0] count_out,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic             inc_edge, dec_edge;
    logic [WIDTH-1:0] count_q, count_nxt;
    logic             carry_q, carry_nxt;
    logic             borrow_q, borrow_nxt;
    logic             step_up, step_down;
    logic             pulses_allowed;
    count_action_e    action;

    rise_edge_detect u_inc_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (manual_inc),
        .rise  (inc_edge)
    );

    rise_edge_detect u_dec_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (manual_dec),
        .rise  (dec_edge)
    );

    always_comb begin
        action         = ACT_HOLD;
        step_up        = 1'b0;
        step_down      = 1'b0;
        pulses_allowed = 1'b0;
        count_nxt      = count_q;
        carry_nxt      = 1'b0;
        borrow_nxt     = 1'b0;

        if (clear)         action = ACT_CLEAR;
        else if (load_en)  action = ACT_LOAD;
        else if (set_mode) action = ACT_MANUAL;
        else if (count_en) action = ACT_RUN;

        case (action)
            ACT_MANUAL: begin
                step_up   = inc_edge & ~dec_edge;
                step_down = dec_edge & ~inc_edge;
            end
            ACT_RUN: begin
                step_up        = (dir == DIR_UP);
                step_down      = (dir == DIR_DOWN);
                pulses_allowed = 1'b1;
            end
            default: ;
        endcase

        // Limits are tested before the add so the count never leaves range.
        case (action)
            ACT_CLEAR: count_nxt = '0;
            ACT_LOAD:  count_nxt = (load_value > MAX_VAL) ? MAX_VAL : load_value;
            default: begin
                if (step_up) begin
                    if (count_q == MAX_VAL) begin
                        if (WRAP != 0) begin
                            count_nxt = '0;
                            carry_nxt = pulses_allowed;
                        end
                    end else begin
                        count_nxt = count_q + 1'b1;
                    end
                end else if (step_down) begin
                    if (count_q == '0) begin
                        if (WRAP != 0) begin
                            count_nxt  = MAX_VAL;
                            borrow_nxt = pulses_allowed;
                        end
                    end else begin
                        count_nxt = count_q - 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_nxt;
            carry_q  <= carry_nxt;
            borrow_q <= borrow_nxt;
        end
    end

    assign count_out  = count_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign at_max     = (count_q == MAX_VAL);
    assign at_zero    = (count_q == '0);

endmodule
